dma_c2h_send_scheduler: RTL and testbench

- Sequences wide snapshot records (io_data, captured on io_enable) onto the XDMA C2H AXI-Stream channel as fixed-width beats.
- Frames records into packets of PKT_RECORDS records, with tlast on the final beat of each packet.
- Throttles the producer through data_next and counts dropped and sent records.
- Sits between the core-side record producer and the m_axis_c2h interface of the DMA IP.

---
 rtl/dma_send_pkg.sv | 22 ++
 rtl/dma_beat_slicer.sv | 20 ++
 rtl/dma_c2h_send_scheduler.sv | 157 +++++++++++++++
 tb/tb_dma_c2h_send_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_send_pkg.sv
// Shared widths, beat geometry and FSM encoding for the C2H send scheduler.
package dma_send_pkg;

  localparam int unsigned DATA_W          = 16000;
  localparam int unsigned BEAT_W          = 512;
  localparam int unsigned KEEP_W          = BEAT_W / 8;
  localparam int unsigned BEATS           = (DATA_W + BEAT_W - 1) / BEAT_W;
  localparam int unsigned PAD_W           = BEATS * BEAT_W;
  localparam int unsigned LAST_BITS       = DATA_W - (BEATS - 1) * BEAT_W;
  localparam int unsigned LAST_BYTES      = (LAST_BITS + 7) / 8;
  localparam int unsigned BIDX_W          = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PKT_RECORDS_DEF = 8;

  // Byte enables for the final, partially filled beat of a record.
  localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/dma_beat_slicer.sv
// Picks one BEAT_W slice of a record (zero padded above DATA_W) plus its tkeep.
module dma_beat_slicer
  import dma_send_pkg::*;
(
  input  logic [DATA_W-1:0] buffer,
  input  logic [BIDX_W-1:0] beat_idx,
  output logic [BEAT_W-1:0] beat_c,
  output logic [KEEP_W-1:0] keep_c
);

  logic [BEATS-1:0][BEAT_W-1:0] padded;

  // Zero-extend the record to whole beats and select the requested one.
  always_comb begin
    padded = PAD_W'(buffer);
    beat_c = padded[beat_idx];
    keep_c = (beat_idx == BIDX_W'(BEATS - 1)) ? LAST_KEEP : {KEEP_W{1'b1}};
  end

endmodule

// File: rtl/dma_c2h_send_scheduler.sv
// Serialises captured records onto the C2H AXI-Stream, framing packets and counting drops.
module dma_c2h_send_scheduler
  import dma_send_pkg::*;
#(
  parameter int unsigned PKT_RECORDS = PKT_RECORDS_DEF
) (
  input  logic              m_axis_c2h_aclk,
  input  logic              rst_en,
  input  logic              io_enable,
  input  logic [DATA_W-1:0] io_data,
  input  logic              flush,
  output logic              data_next,
  output logic [BEAT_W-1:0] m_axis_c2h_tdata,
  output logic [KEEP_W-1:0] m_axis_c2h_tkeep,
  output logic              m_axis_c2h_tvalid,
  input  logic              m_axis_c2h_tready,
  output logic              m_axis_c2h_tlast,
  output logic [31:0]       sent_count,
  output logic [31:0]       drop_count,
  output logic              overflow
);

  localparam int unsigned PIDX_W = (PKT_RECORDS > 1) ? $clog2(PKT_RECORDS) : 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [BIDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [PIDX_W-1:0]   pkt_idx_q, pkt_idx_d;
  logic                flush_pending_q, flush_pending_d;
  logic                data_next_q, data_next_d;
  logic                tvalid_q, tvalid_d;
  logic [BEAT_W-1:0]   tdata_q, tdata_d;
  logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
  logic                tlast_q, tlast_d;
  logic [31:0]         sent_q, sent_d;
  logic [31:0]         drop_q, drop_d;
  logic                overflow_q, overflow_d;

  logic                accept_c, hs_c, last_hs_c, load_c;
  logic [BEAT_W-1:0]   slice_beat_c;
  logic [KEEP_W-1:0]   slice_keep_c;

  // Slice is taken from the next-cycle buffer/index so the beat register loads in step.
  dma_beat_slicer u_slicer (
    .buffer   (buf_d),
    .beat_idx (beat_idx_d),
    .beat_c   (slice_beat_c),
    .keep_c   (slice_keep_c)
  );

  // FSM, record buffer, counters and packet framing state.
  always_comb begin
    accept_c        = (state_q == IDLE) && io_enable;
    hs_c            = tvalid_q && m_axis_c2h_tready;
    last_hs_c       = hs_c && (beat_idx_q == BIDX_W'(BEATS - 1));
    state_d         = state_q;
    buf_d           = buf_q;
    beat_idx_d      = beat_idx_q;
    pkt_idx_d       = pkt_idx_q;
    flush_pending_d = flush_pending_q;
    sent_d          = sent_q;
    drop_d          = drop_q;
    overflow_d      = overflow_q;

    if (accept_c) begin
      state_d    = SEND;
      buf_d      = io_data;
      beat_idx_d = '0;
    end else if (hs_c) begin
      beat_idx_d = beat_idx_q + BIDX_W'(1);
    end

    if (last_hs_c) begin
      state_d   = IDLE;
      sent_d    = sent_q + 32'd1;
      pkt_idx_d = tlast_q ? '0 : pkt_idx_q + PIDX_W'(1);
      if (tlast_q) flush_pending_d = 1'b0;
    end

    // A flush landing on the closing handshake survives the clear above.
    if (flush) flush_pending_d = 1'b1;

    if ((state_q == SEND) && io_enable) begin
      drop_d     = drop_q + 32'd1;
      overflow_d = 1'b1;
    end

    data_next_d = (state_d == IDLE);
  end

  // Output beat register: reloads only when empty or when the current beat is taken.
  always_comb begin
    load_c   = !tvalid_q || m_axis_c2h_tready;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    if (load_c) begin
      tvalid_d = (state_d == SEND);
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
      if (state_d == SEND) begin
        tdata_d = slice_beat_c;
        tkeep_d = slice_keep_c;
        tlast_d = (beat_idx_d == BIDX_W'(BEATS - 1)) &&
                  ((pkt_idx_d == PIDX_W'(PKT_RECORDS - 1)) || flush_pending_d);
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (rst_en) begin
      state_q         <= IDLE;
      beat_idx_q      <= '0;
      pkt_idx_q       <= '0;
      flush_pending_q <= 1'b0;
      data_next_q     <= 1'b0;
      tvalid_q        <= 1'b0;
      tdata_q         <= '0;
      tkeep_q         <= '0;
      tlast_q         <= 1'b0;
      sent_q          <= '0;
      drop_q          <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_idx_q      <= beat_idx_d;
      pkt_idx_q       <= pkt_idx_d;
      flush_pending_q <= flush_pending_d;
      data_next_q     <= data_next_d;
      tvalid_q        <= tvalid_d;
      tdata_q         <= tdata_d;
      tkeep_q         <= tkeep_d;
      tlast_q         <= tlast_d;
      sent_q          <= sent_d;
      drop_q          <= drop_d;
      overflow_q      <= overflow_d;
    end
  end

  // Record buffer carries no reset; it is only read after an accept overwrites it.
  always_ff @(posedge m_axis_c2h_aclk) begin
    buf_q <= buf_d;
  end

  assign data_next         = data_next_q;
  assign m_axis_c2h_tvalid = tvalid_q;
  assign m_axis_c2h_tdata  = tdata_q;
  assign m_axis_c2h_tkeep  = tkeep_q;
  assign m_axis_c2h_tlast  = tlast_q;
  assign sent_count        = sent_q;
  assign drop_count        = drop_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_dma_c2h_send_scheduler.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks them.
module tb_dma_c2h_send_scheduler;
  import dma_send_pkg::*;

  logic              clk = 1'b0;
  logic              rst_en = 1'b1;
  logic              io_enable = 1'b0;
  logic [DATA_W-1:0] io_data = '0;
  logic              flush = 1'b0;
  logic              data_next;
  logic [BEAT_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready = 1'b1;
  logic              tlast;
  logic [31:0]       sent_count;
  logic [31:0]       drop_count;
  logic              overflow;

  typedef struct {
    logic [BEAT_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    bp_mode = 0;
  int    bp_cyc = 0;

  dma_c2h_send_scheduler dut (
    .m_axis_c2h_aclk   (clk),
    .rst_en            (rst_en),
    .io_enable         (io_enable),
    .io_data           (io_data),
    .flush             (flush),
    .data_next         (data_next),
    .m_axis_c2h_tdata  (tdata),
    .m_axis_c2h_tkeep  (tkeep),
    .m_axis_c2h_tvalid (tvalid),
    .m_axis_c2h_tready (tready),
    .m_axis_c2h_tlast  (tlast),
    .sent_count        (sent_count),
    .drop_count        (drop_count),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // tready: always high, or the repeating 1,0,0,1 backpressure pattern.
  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) tready = 1'b1;
    else begin
      tready = (bp_cyc % 4 == 0) || (bp_cyc % 4 == 3);
      bp_cyc++;
    end
  end

  // Monitor: stall stability and in-order beat comparison against the scoreboard.
  logic              stall_prev = 1'b0;
  logic [BEAT_W-1:0] prev_d;
  logic [KEEP_W-1:0] prev_k;
  logic              prev_l;
  always @(negedge clk) begin
    beat_t e;
    if (rst_en) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("stall_tvalid", BEAT_W'(tvalid), BEAT_W'(1));
        chk("stall_tdata", tdata, prev_d);
        chk("stall_tkeep", BEAT_W'(tkeep), BEAT_W'(prev_k));
        chk("stall_tlast", BEAT_W'(tlast), BEAT_W'(prev_l));
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) chk("unexpected_beat", BEAT_W'(1), BEAT_W'(0));
        else begin
          e = sb.pop_front();
          chk("tdata", tdata, e.d);
          chk("tkeep", BEAT_W'(tkeep), BEAT_W'(e.k));
          chk("tlast", BEAT_W'(tlast), BEAT_W'(e.l));
        end
      end
      stall_prev = tvalid && !tready;
      prev_d = tdata;
      prev_k = tkeep;
      prev_l = tlast;
    end
  end

  // Record whose beats carry a seed/beat-number signature in their low 64 bits.
  function automatic logic [DATA_W-1:0] mk_rec(input int seed);
    logic [PAD_W-1:0] p;
    logic [31:0]      w;
    p = '0;
    for (int k = 0; k < int'(BEATS); k++) begin
      w = {16'(seed), 16'(k)};
      p[k*BEAT_W +: 32] = w;
      p[k*BEAT_W + 32 +: 32] = ~w;
    end
    return p[DATA_W-1:0];
  endfunction

  task automatic push_rec(input logic [DATA_W-1:0] rec, input logic last);
    logic [PAD_W-1:0] p;
    beat_t e;
    p = PAD_W'(rec);
    for (int k = 0; k < 32; k++) begin
      e.d = p[k*BEAT_W +: BEAT_W];
      e.k = (k == 31) ? 64'h0000_0000_0000_FFFF : {KEEP_W{1'b1}};
      e.l = (k == 31) ? last : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic send_rec(input logic [DATA_W-1:0] rec, input logic last);
    int n = 0;
    while (!data_next && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (!data_next) chk("data_next_timeout", BEAT_W'(0), BEAT_W'(1));
    io_enable = 1'b1;
    io_data   = rec;
    push_rec(rec, last);
    @(posedge clk); #1;
    io_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb.size() == 0 && data_next) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_done", BEAT_W'(sb.size() == 0 && data_next), BEAT_W'(1));
  endtask

  task automatic do_reset();
    rst_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("reset_outputs", BEAT_W'({data_next, tvalid, tlast, overflow, |tdata, |tkeep,
                                    |sent_count, |drop_count}), BEAT_W'(0));
    end
    rst_en = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_data_next", BEAT_W'(data_next), BEAT_W'(1));
    chk("post_reset_tvalid", BEAT_W'(tvalid), BEAT_W'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog sim_time_exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DATA_W-1:0] one;

    // Single record of value 1, tready always high.
    bp_mode = 0;
    do_reset();
    one = '0;
    one[0] = 1'b1;
    send_rec(one, 1'b0);
    n = 0;
    while (!data_next && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("data_next_return_cycles", BEAT_W'(n), BEAT_W'(32));
    chk("single_sent", BEAT_W'(sent_count), BEAT_W'(1));
    wait_idle();

    // Eight back-to-back records: tlast only on the eighth.
    do_reset();
    for (int r = 1; r <= 8; r++) send_rec(mk_rec(r), r == 8);
    wait_idle();
    chk("eight_sent", BEAT_W'(sent_count), BEAT_W'(8));

    // Backpressure with tready pattern 1,0,0,1.
    do_reset();
    bp_mode = 1;
    bp_cyc = 0;
    send_rec(mk_rec(9), 1'b0);
    wait_idle();
    chk("bp_sent", BEAT_W'(sent_count), BEAT_W'(1));

    // Drops while a record is in flight under backpressure.
    do_reset();
    send_rec(mk_rec(10), 1'b0);
    for (int i = 0; i < 3; i++) begin
      io_enable = 1'b1;
      io_data   = mk_rec(99);
      @(posedge clk); #1;
      io_enable = 1'b0;
      @(posedge clk); #1;
    end
    wait_idle();
    chk("drop_count", BEAT_W'(drop_count), BEAT_W'(3));
    chk("overflow_set", BEAT_W'(overflow), BEAT_W'(1));
    chk("drop_sent", BEAT_W'(sent_count), BEAT_W'(1));
    send_rec(mk_rec(11), 1'b0);
    wait_idle();
    chk("overflow_sticky", BEAT_W'(overflow), BEAT_W'(1));
    chk("drop_count_hold", BEAT_W'(drop_count), BEAT_W'(3));

    // Flush during record 3 closes that packet; the next packet is 8 records.
    bp_mode = 0;
    do_reset();
    send_rec(mk_rec(21), 1'b0);
    send_rec(mk_rec(22), 1'b0);
    send_rec(mk_rec(23), 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int r = 1; r <= 8; r++) send_rec(mk_rec(30 + r), r == 8);
    wait_idle();
    chk("flush_sent", BEAT_W'(sent_count), BEAT_W'(11));
    chk("sb_empty", BEAT_W'(sb.size()), BEAT_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
